// File: rtl/max7219_stream_writer_pkg.sv
// max7219_types: MAX7219 register map, writer FSM states and power-up word table
package max7219_types;
    localparam logic [3:0] HDR              = 4'h0;
    localparam logic [3:0] REG_ROW_0        = 4'h1;
    localparam logic [3:0] REG_ROW_1        = 4'h2;
    localparam logic [3:0] REG_ROW_2        = 4'h3;
    localparam logic [3:0] REG_ROW_3        = 4'h4;
    localparam logic [3:0] REG_ROW_4        = 4'h5;
    localparam logic [3:0] REG_ROW_5        = 4'h6;
    localparam logic [3:0] REG_ROW_6        = 4'h7;
    localparam logic [3:0] REG_ROW_7        = 4'h8;
    localparam logic [3:0] REG_DECODE       = 4'h9;
    localparam logic [3:0] REG_INTENSITY    = 4'hA;
    localparam logic [3:0] REG_SCAN_LIMIT   = 4'hB;
    localparam logic [3:0] REG_SHUTDOWN     = 4'hC;
    localparam logic [3:0] REG_DISPLAY_TEST = 4'hF;
    localparam logic [2:0] N_INIT           = 3'd5;

    typedef enum logic [2:0] {IDLE, INIT, LATCH, SHIFT, HOLD, GAP} state_t;

    function automatic logic [15:0] init_word(input logic [2:0] i, input logic [3:0] inten);
        return i == 3'd0 ? {HDR, REG_DISPLAY_TEST, 8'h00} :
               i == 3'd1 ? {HDR, REG_SCAN_LIMIT, 8'h07} :
               i == 3'd2 ? {HDR, REG_DECODE, 8'h00} :
               i == 3'd3 ? {HDR, REG_INTENSITY, 4'h0, inten} :
                           {HDR, REG_SHUTDOWN, 8'h01};
    endfunction
endpackage

// File: rtl/max7219_stream_writer_if.sv
// max7219_stream_writer_if: parallel load, start/done handshake and serial pins of the shifter
interface max7219_stream_writer_if #(parameter int W = 16);
    logic         start;
    logic         done;
    logic [W-1:0] data;
    logic         sclk;
    logic         din;
    modport master (output start, output data, input done, input sclk, input din);
    modport slave (input start, input data, output done, output sclk, output din);
endinterface

// File: rtl/max7219_spi_shift.sv
// max7219_spi_shift: loads WIDTH bits on start and shifts them MSB first, CLK_DIV cycles per half bit
module max7219_spi_shift #(
    parameter int WIDTH   = 16,
    parameter int CLK_DIV = 6
) (
    input logic i_Clk,
    input logic i_Rst,
    max7219_stream_writer_if.slave bus
);
    localparam int BW = $clog2(WIDTH + 1);
    localparam int DW = $clog2(CLK_DIV + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
    localparam logic [DW-1:0] LAST_DIV = DW'(CLK_DIV - 1);

    logic             busy_q, busy_d, sclk_q, sclk_d, din_q, din_d, tick, last;
    logic [BW-1:0]    bit_q, bit_d;
    logic [DW-1:0]    div_q, div_d;
    logic [WIDTH-1:0] sh_q, sh_d;

    assign bus.done = last;
    assign bus.sclk = sclk_q;
    assign bus.din  = din_q;

    always_comb begin
        tick   = busy_q && div_q == LAST_DIV;
        last   = tick && sclk_q && bit_q == LAST_BIT;
        busy_d = busy_q;
        sclk_d = sclk_q;
        din_d  = din_q;
        bit_d  = bit_q;
        sh_d   = sh_q;
        div_d  = busy_q && !tick ? div_q + 1'b1 : '0;
        if (!busy_q && bus.start) begin
            busy_d = 1'b1;
            sh_d   = bus.data;
            din_d  = bus.data[WIDTH-1];
            sclk_d = 1'b0;
            bit_d  = '0;
        end else if (tick) begin
            sclk_d = !sclk_q;
            // zeros shift in behind the word, so DIN settles low after the last bit
            if (sclk_q) begin
                bit_d  = bit_q + 1'b1;
                sh_d   = sh_q << 1;
                din_d  = sh_q[WIDTH-2];
                busy_d = !last;
            end
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst)
        if (i_Rst) begin
            busy_q <= 1'b0;
            sclk_q <= 1'b0;
            din_q  <= 1'b0;
            bit_q  <= '0;
            div_q  <= '0;
            sh_q   <= '0;
        end else begin
            busy_q <= busy_d;
            sclk_q <= sclk_d;
            din_q  <= din_d;
            bit_q  <= bit_d;
            div_q  <= div_d;
            sh_q   <= sh_d;
        end
endmodule

// File: rtl/max7219_stream_writer.sv
// max7219_stream_writer: power-up register writes, then endless refresh of eight row streams
module max7219_stream_writer
    import max7219_types::*;
#(
    parameter int         DISP_ROWS    = 1,
    parameter int         DISP_COLUMNS = 1,
    parameter int         CLK_DIV      = 6,
    parameter logic [3:0] INTENSITY    = 4'h8
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic [0:7][DISP_ROWS-1:0][DISP_COLUMNS-1:0][15:0] i_MAX7219_DataStream,
    output logic o_MAX7219_CLK,
    output logic o_MAX7219_DIN,
    output logic o_MAX7219_CS,
    output logic o_FrameDone
);
    localparam int N  = DISP_ROWS * DISP_COLUMNS;
    localparam int W  = 16 * N;
    localparam int DW = $clog2(CLK_DIV + 1);
    localparam logic [DW-1:0] LAST_DIV = DW'(CLK_DIV - 1);

    state_t        state_q, state_d;
    logic [2:0]    s_q, s_d, idx_q, idx_d, nxt_i, nxt_s;
    logic [DW-1:0] cnt_q, cnt_d;
    logic          cs_q, cs_d, fd_q, fd_d, last, init_nxt;

    max7219_stream_writer_if #(.W(W)) bus ();
    max7219_spi_shift #(.WIDTH(W), .CLK_DIV(CLK_DIV)) u_shift (.i_Clk, .i_Rst, .bus(bus));

    assign o_MAX7219_CLK = bus.sclk;
    assign o_MAX7219_DIN = bus.din;
    assign o_MAX7219_CS  = cs_q;
    assign o_FrameDone   = fd_q;

    // idx_q numbers the power-up write in flight; N_INIT marks streaming
    always_comb begin
        last      = cnt_q == LAST_DIV;
        nxt_i     = state_q == IDLE ? 3'd0 : idx_q + 3'd1;
        init_nxt  = nxt_i < N_INIT;
        nxt_s     = idx_q == N_INIT ? s_q + 3'd1 : 3'd0;
        bus.start = state_q == IDLE || (state_q == GAP && last);
        bus.data  = init_nxt ? {N{init_word(nxt_i, INTENSITY)}} : i_MAX7219_DataStream[nxt_s];
        cnt_d     = (state_q == HOLD || state_q == GAP) && !last ? cnt_q + 1'b1 : '0;
        state_d   = state_q;
        s_d       = s_q;
        idx_d     = idx_q;
        cs_d      = cs_q;
        fd_d      = 1'b0;
        if (bus.start) begin
            cs_d    = 1'b0;
            state_d = init_nxt ? INIT : LATCH;
            idx_d   = init_nxt ? nxt_i : N_INIT;
            s_d     = init_nxt ? s_q : nxt_s;
        end else if (state_q == LATCH) begin
            state_d = SHIFT;
        end else if (bus.done) begin
            state_d = HOLD;
        end else if (state_q == HOLD && last) begin
            state_d = GAP;
            cs_d    = 1'b1;
            fd_d    = idx_q == N_INIT && s_q == 3'd7;
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst)
        if (i_Rst) begin
            state_q <= IDLE;
            s_q     <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            cs_q    <= 1'b1;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            cs_q    <= cs_d;
            fd_q    <= fd_d;
        end
endmodule

// File: tb/tb_max7219_stream_writer.sv
// tb_max7219_stream_writer: scoreboard of serial words for a 1x2 chain (CLK_DIV=2) and a single device (CLK_DIV=1)
module tb_max7219_stream_writer;
    logic clk = 1'b0;
    logic rst0, rst1;
    logic [0:7][0:0][1:0][15:0] ds0;
    logic [0:7][0:0][0:0][15:0] ds1;
    logic sclk0, din0, cs0, fd0, cs1, fd1;
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [15:0] iw[5] = '{16'h0F00, 16'h0B07, 16'h0900, 16'h0A08, 16'h0C01};
    int vectors = 0;
    int miscompares = 0;
    int ndone[2];
    int edges[2];

    max7219_stream_writer_if #(.W(16)) pin ();

    wire [1:0] rst_w  = {rst1, rst0};
    wire [1:0] sclk_w = {pin.sclk, sclk0};
    wire [1:0] din_w  = {pin.din, din0};
    wire [1:0] cs_w   = {cs1, cs0};
    wire [1:0] fd_w   = {fd1, fd0};

    always #5 clk = ~clk;

    max7219_stream_writer #(.DISP_ROWS(1), .DISP_COLUMNS(2), .CLK_DIV(2)) dut0 (
        .i_Clk(clk), .i_Rst(rst0), .i_MAX7219_DataStream(ds0),
        .o_MAX7219_CLK(sclk0), .o_MAX7219_DIN(din0), .o_MAX7219_CS(cs0), .o_FrameDone(fd0)
    );

    max7219_stream_writer #(.DISP_ROWS(1), .DISP_COLUMNS(1), .CLK_DIV(1)) dut1 (
        .i_Clk(clk), .i_Rst(rst1), .i_MAX7219_DataStream(ds1),
        .o_MAX7219_CLK(pin.sclk), .o_MAX7219_DIN(pin.din), .o_MAX7219_CS(cs1), .o_FrameDone(fd1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_cnt(input int g, input int n);
        int t = 0;
        while (ndone[g] < n && t < 5000) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk($sformatf("done%0d_reach_%0d", g, n), 32'(ndone[g] >= n), 32'd1);
    endtask

    task automatic wait_edges(input int g, input int n);
        int t = 0;
        while (!(cs_w[g] == 1'b0 && edges[g] == n) && t < 5000) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk($sformatf("edges%0d_reach_%0d", g, n), 32'(edges[g]), 32'(n));
    endtask

    task automatic push0_init();
        for (int i = 0; i < 5; i++) q0.push_back({iw[i], iw[i]});
    endtask

    task automatic push0_streams(input int cnt);
        for (int s = 0; s < cnt; s++) q0.push_back({ds0[s][0][1], ds0[s][0][0]});
    endtask

    for (genvar g = 0; g < 2; g++) begin : mon
        localparam int DIV = g == 0 ? 2 : 1;
        localparam int WB  = g == 0 ? 32 : 16;
        localparam int PER = 8 * (2 * WB + 2) * DIV;
        int lowc, hic, cyc, fd_rise, last_fd, qs;
        logic [31:0] cap, w;
        logic pcs, psc, pfd, seen;
        initial begin
            pcs = 1'b1; psc = 1'b0; pfd = 1'b0; seen = 1'b0;
            lowc = 0; hic = 0; cyc = 0; fd_rise = 0; last_fd = 0; cap = '0; w = '0;
            ndone[g] = 0; edges[g] = 0;
            forever begin
                @(negedge clk);
                cyc++;
                if (rst_w[g]) begin
                    pcs = 1'b1; psc = 1'b0; pfd = 1'b0; seen = 1'b0;
                    ndone[g] = 0; edges[g] = 0; last_fd = 0;
                end else begin
                    if (!cs_w[g]) begin
                        if (pcs) begin
                            if (seen) chk($sformatf("gap_len%0d", g), 32'(hic), 32'(DIV));
                            lowc = 0; edges[g] = 0; cap = '0;
                        end
                        lowc++;
                        if (sclk_w[g] && !psc) begin
                            edges[g]++;
                            cap = {cap[30:0], din_w[g]};
                        end
                    end else begin
                        if (!pcs) begin
                            hic = 0;
                            ndone[g]++;
                            seen = 1'b1;
                            if (g == 0) qs = q0.size(); else qs = q1.size();
                            if (qs > 0) begin
                                if (g == 0) w = q0.pop_front(); else w = q1.pop_front();
                                chk($sformatf("word%0d_t%0d", g, ndone[g]), cap, w);
                                chk($sformatf("rise_edges%0d_t%0d", g, ndone[g]), 32'(edges[g]), 32'(WB));
                                chk($sformatf("cs_low%0d_t%0d", g, ndone[g]), 32'(lowc), 32'((2 * WB + 1) * DIV));
                            end
                        end
                        hic++;
                    end
                    if (fd_w[g] && !pfd) begin
                        fd_rise = cyc;
                        chk($sformatf("fd_first_gap%0d", g), 32'(hic), 32'd1);
                        chk($sformatf("fd_stream7_%0d", g), 32'((ndone[g] - 5) % 8), 32'd0);
                        if (last_fd != 0) chk($sformatf("fd_period%0d", g), 32'(cyc - last_fd), 32'(PER));
                        last_fd = cyc;
                    end
                    if (!fd_w[g] && pfd) chk($sformatf("fd_width%0d", g), 32'(cyc - fd_rise), 32'd1);
                    pcs = cs_w[g]; psc = sclk_w[g]; pfd = fd_w[g];
                end
            end
        end
    end

    initial begin
        pin.start = 1'b0;
        pin.done  = 1'b0;
        pin.data  = '0;
        rst0 = 1'b1;
        rst1 = 1'b1;
        for (int s = 0; s < 8; s++) begin
            ds0[s][0][1] = s == 0 ? 16'h0102 : 16'h1000 + 16'(s);
            ds0[s][0][0] = s == 0 ? 16'h0304 : 16'h2000 + 16'(s);
            ds1[s][0][0] = s == 0 ? 16'h01A5 : 16'h5A00 + 16'(s);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cs0", 32'(cs0), 32'd1);
        chk("rst_clk0", 32'(sclk0), 32'd0);
        chk("rst_din0", 32'(din0), 32'd0);
        chk("rst_fd0", 32'(fd0), 32'd0);
        chk("rst_cs1", 32'(cs1), 32'd1);
        chk("rst_clk1", 32'(pin.sclk), 32'd0);
        chk("rst_fd1", 32'(fd1), 32'd0);

        push0_init();
        push0_streams(8);
        for (int i = 0; i < 5; i++) q1.push_back({16'h0, iw[i]});
        for (int p = 0; p < 3; p++)
            for (int s = 0; s < 8; s++) q1.push_back({16'h0, ds1[s][0][0]});

        @(posedge clk);
        #1;
        rst0 = 1'b0;
        rst1 = 1'b0;
        @(posedge clk);
        #1;
        chk("start_cs0", 32'(cs0), 32'd0);
        chk("start_din0", 32'(din0), 32'd0);
        chk("start_clk0", 32'(sclk0), 32'd0);
        chk("start_cs1", 32'(cs1), 32'd0);

        wait_cnt(0, 7);
        wait_edges(0, 3);
        ds0[2][0][1] = 16'hDEAD;
        ds0[2][0][0] = 16'hBEEF;
        push0_streams(8);

        wait_cnt(0, 16);
        wait_edges(0, 7);
        #1;
        rst0 = 1'b1;
        #1;
        chk("midrst_cs0", 32'(cs0), 32'd1);
        chk("midrst_clk0", 32'(sclk0), 32'd0);
        chk("midrst_din0", 32'(din0), 32'd0);
        q0.delete();
        push0_init();
        push0_streams(2);
        repeat (2) @(posedge clk);
        #1;
        rst0 = 1'b0;
        wait_cnt(0, 7);

        wait_cnt(1, 29);
        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/max7219_stream_writer.md
MAX7219_STREAM_WRITER -- requirements
Module: max7219_stream_writer

Interface
REQ-001 SHALL have parameter DISP_ROWS, default 1: number of rows of 8x8 displays in the chain.
REQ-002 SHALL have parameter DISP_COLUMNS, default 1: number of columns of 8x8 displays in the chain.
REQ-003 SHALL have parameter CLK_DIV, default 6: i_Clk cycles per half period of o_MAX7219_CLK, minimum 1.
REQ-004 SHALL have parameter INTENSITY, default 4'h8: value written to the MAX7219 intensity register.
REQ-005 SHALL have port i_Clk, input, 1 bit: the single clock; all logic runs on its rising edge.
REQ-006 SHALL have port i_Rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port i_MAX7219_DataStream, input, [0:7][DISP_ROWS-1:0][DISP_COLUMNS-1:0][15:0]: eight row streams from the pattern generator.
REQ-008 SHALL have port o_MAX7219_CLK, output, 1 bit: serial clock.
REQ-009 SHALL have port o_MAX7219_DIN, output, 1 bit: serial data.
REQ-010 SHALL have port o_MAX7219_CS, output, 1 bit: LOAD/CS, active-low.
REQ-011 SHALL have port o_FrameDone, output, 1 bit: one-cycle pulse after row stream 7 is loaded.

Function
REQ-012 N = DISP_ROWS*DISP_COLUMNS; one transaction SHALL shift 16*N bits, one 16-bit word per device.
REQ-013 Within a transaction, words SHALL be sent in descending flattened index (k = r*DISP_COLUMNS + c, from N-1 down to 0), each word MSB first.
REQ-014 Transaction timing: on cycle 0, CS goes low, CLK is low and DIN carries the first bit.
REQ-015 Each bit SHALL hold CLK low for CLK_DIV cycles, then high for CLK_DIV cycles; DIN changes only on the cycle CLK goes low.
REQ-016 After the last high phase, CLK SHALL return low with CS still low for CLK_DIV cycles.
REQ-017 CS SHALL then rise and stay high for CLK_DIV cycles (gap).
REQ-018 Total transaction length SHALL be (32*N+2)*CLK_DIV cycles.
REQ-019 FSM states SHALL be IDLE, INIT, LATCH, SHIFT, HOLD, GAP.
REQ-020 After reset, the FSM SHALL run 5 INIT transactions, each word replicated to all N devices as {4'h0, addr, data}, in this order: DISPLAY_TEST=0x00, SCAN_LIMIT=0x07, DECODE=0x00, INTENSITY={4'h0,INTENSITY}, SHUTDOWN=0x01.
REQ-021 After INIT, the FSM SHALL loop over streams s = 0..7: LATCH snapshots i_MAX7219_DataStream[s] (all N words), then SHIFT, HOLD, GAP; s wraps from 7 to 0 indefinitely.
REQ-022 Input changes after LATCH SHALL not affect the current transaction (no tearing within a stream).
REQ-023 o_FrameDone SHALL pulse high for exactly 1 cycle on the first GAP cycle of stream 7.
REQ-024 The bit counter SHALL be $clog2(16*N+1) bits wide and the divider counter $clog2(CLK_DIV+1) bits wide; neither SHALL overflow.
REQ-025 With CLK_DIV=1, CLK SHALL still toggle every cycle with no lost bits.

Reset
REQ-026 While i_Rst is high, outputs SHALL be CLK=0, DIN=0, CS=1, o_FrameDone=0, FSM=IDLE, s=0.
REQ-027 Assertion of i_Rst SHALL take effect immediately, including mid-transaction: CS is forced high with no partial LOAD completing.
REQ-028 After i_Rst deasserts, INIT SHALL start on the first rising edge of i_Clk.

Structure
REQ-029 The register addresses REG_DECODE=4'h9, REG_INTENSITY=4'hA, REG_SCAN_LIMIT=4'hB, REG_SHUTDOWN=4'hC and REG_DISPLAY_TEST=4'hF SHALL live in package max7219_types, beside HDR and REG_ROW_0..7.
REQ-030 The serialiser SHALL be sub-module max7219_spi_shift, with parameters WIDTH=16*N and CLK_DIV, a start/done handshake and a parallel load.
REQ-031 The top level SHALL hold the FSM, the stream index and the word muxing.

Verification
REQ-032 N=1, CLK_DIV=2, reset released -> first transaction word 0x0F00, CS low for 66 cycles, then 2 cycles high; total 68 cycles.
REQ-033 N=1 after INIT, stream 0 = 0x01A5 -> DIN sequence 0000000110100101 sampled on CLK rising edges, exactly 16 rising edges while CS is low.
REQ-034 DISP_COLUMNS=2, words [0][1]=0x0102, [0][0]=0x0304 -> 0x0102 shifted first, 32 rising edges per CS-low window.
REQ-035 Input changed mid-SHIFT -> shifted bits match the LATCH snapshot; the new value appears in the next pass of that stream.
REQ-036 i_Rst pulsed at bit 7 of stream 3 -> CS=1, CLK=0 in the same cycle; next transaction is DISPLAY_TEST=0x0F00.
REQ-037 Free run, N=1, CLK_DIV=1 -> o_FrameDone period = 8*34 cycles = 272; exactly one pulse per period.
